// File: rtl/data_flow_collector.sv
// Serial word deserializer: packs NUM_NEURON_LAYER words (LSB-first) into one vector.
// A gap watchdog discards partial frames that stall too long.
`ifndef dataWidth
`define dataWidth 16
`endif

module data_flow_collector #(
  parameter int NUM_NEURON_LAYER = 30,
  parameter int GAP_TIMEOUT      = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   data_in_valid,
  input  logic [`dataWidth-1:0]                  in_data,
  output logic                                   x_valid,
  output logic [NUM_NEURON_LAYER*`dataWidth-1:0] x_out,
  output logic [$clog2(NUM_NEURON_LAYER+1)-1:0]  words_held,
  output logic                                   busy,
  output logic                                   frame_error
);

  localparam int W  = `dataWidth;
  localparam int VW = NUM_NEURON_LAYER * W;
  localparam int CW = $clog2(NUM_NEURON_LAYER + 1);
  localparam int GW = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    (GAP_TIMEOUT > 0) ? GW'(GAP_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_NEURON_LAYER - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state, state_n;
  logic [VW-1:0]   shreg, shreg_n, shifted, x_out_n;
  logic [CW-1:0]   count_n;
  logic [GW-1:0]   gap, gap_n;
  logic            x_valid_n, frame_error_n;
  logic            last, timeout;

  // New words enter at the top slice so word 0 ends in the lowest slice.
  generate
    if (NUM_NEURON_LAYER == 1) begin : g_single
      assign shifted = in_data;
    end else begin : g_multi
      assign shifted = {in_data, shreg[VW-1:W]};
    end
  endgenerate

  assign last    = (words_held == LAST_IDX);
  assign timeout = (GAP_TIMEOUT > 0) && (gap == GAP_LAST);
  assign busy    = (state == COLLECT);

  always_comb begin
    state_n       = state;
    shreg_n       = shreg;
    count_n       = words_held;
    gap_n         = gap;
    x_out_n       = x_out;
    x_valid_n     = 1'b0;
    frame_error_n = 1'b0;
    if (data_in_valid) begin
      shreg_n = shifted;
      gap_n   = '0;
      if (last) begin
        x_out_n   = shifted;
        x_valid_n = 1'b1;
        count_n   = '0;
        state_n   = IDLE;
      end else begin
        count_n = words_held + CW'(1);
        state_n = COLLECT;
      end
    end else if (state == COLLECT) begin
      if (timeout) begin
        state_n       = IDLE;
        count_n       = '0;
        gap_n         = '0;
        frame_error_n = 1'b1;
      end else if (GAP_TIMEOUT > 0) begin
        gap_n = gap + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      words_held  <= '0;
      gap         <= '0;
      x_out       <= '0;
      x_valid     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      words_held  <= count_n;
      gap         <= gap_n;
      x_out       <= x_out_n;
      x_valid     <= x_valid_n;
      frame_error <= frame_error_n;
    end
  end

endmodule

// File: tb/tb_data_flow_collector.sv
// Bench for data_flow_collector: queue-style model checked every cycle,
// plus literal expectations on key frames. Two builds: timeout 5 and 0.
`define dataWidth 16

module tb_data_flow_collector;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        av, bv;
  logic [15:0] ad, bd;
  logic        a_xv, b_xv, a_busy, b_busy, a_fe, b_fe;
  logic [63:0] a_xo, b_xo;
  logic [2:0]  a_wh, b_wh;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_flow_collector #(.NUM_NEURON_LAYER(N), .GAP_TIMEOUT(5)) dut_a (
    .clk(clk), .reset(reset), .data_in_valid(av), .in_data(ad),
    .x_valid(a_xv), .x_out(a_xo), .words_held(a_wh),
    .busy(a_busy), .frame_error(a_fe)
  );

  data_flow_collector #(.NUM_NEURON_LAYER(N), .GAP_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .data_in_valid(bv), .in_data(bd),
    .x_valid(b_xv), .x_out(b_xo), .words_held(b_wh),
    .busy(b_busy), .frame_error(b_fe)
  );

  // Model state per build (0: timeout 5, 1: timeout 0)
  int          tmo [2] = '{5, 0};
  logic [15:0] hold [2][N];
  int          n    [2];
  int          idle [2];
  logic [63:0] m_xo [2];
  logic        m_xv [2];
  logic        m_fe [2];
  int          xv_cnt [2];
  int          fe_cnt [2];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic v,
                            input logic [15:0] d);
    if (r) begin
      n[i] = 0; idle[i] = 0; m_xo[i] = '0; m_xv[i] = 0; m_fe[i] = 0;
      return;
    end
    m_xv[i] = 0;
    m_fe[i] = 0;
    if (v) begin
      hold[i][n[i]] = d;
      n[i]++;
      idle[i] = 0;
      if (n[i] == N) begin
        for (int k = 0; k < N; k++) m_xo[i][k*16 +: 16] = hold[i][k];
        m_xv[i] = 1;
        n[i] = 0;
      end
    end else if (n[i] > 0 && tmo[i] > 0) begin
      idle[i]++;
      if (idle[i] == tmo[i]) begin
        n[i] = 0; idle[i] = 0; m_fe[i] = 1;
      end
    end
  endtask

  task automatic compare();
    chk("a_x_valid", 64'(a_xv), 64'(m_xv[0]));
    chk("a_x_out", a_xo, m_xo[0]);
    chk("a_words_held", 64'(a_wh), 64'(n[0]));
    chk("a_busy", 64'(a_busy), 64'(n[0] > 0));
    chk("a_frame_error", 64'(a_fe), 64'(m_fe[0]));
    chk("b_x_valid", 64'(b_xv), 64'(m_xv[1]));
    chk("b_x_out", b_xo, m_xo[1]);
    chk("b_words_held", 64'(b_wh), 64'(n[1]));
    chk("b_busy", 64'(b_busy), 64'(n[1] > 0));
    chk("b_frame_error", 64'(b_fe), 64'(m_fe[1]));
    if (a_xv) xv_cnt[0]++;
    if (b_xv) xv_cnt[1]++;
    if (a_fe) fe_cnt[0]++;
    if (b_fe) fe_cnt[1]++;
    total++;
    if ((a_xv && a_fe) || (b_xv && b_fe)) begin
      bad++;
      $display("FAIL pulse_overlap: x_valid and frame_error both high");
    end
  endtask

  task automatic cyc(input logic r, input logic va, input logic [15:0] da,
                     input logic vb, input logic [15:0] db);
    reset = r; av = va; ad = da; bv = vb; bd = db;
    @(posedge clk);
    model_step(0, r, va, da);
    model_step(1, r, vb, db);
    #1;
    compare();
  endtask

  task automatic wa(input logic [15:0] d);
    cyc(1'b0, 1'b1, d, 1'b0, 16'h0);
  endtask

  task automatic ia(input int k);
    for (int j = 0; j < k; j++) cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  int base;

  initial begin
    reset = 1'b1; av = 0; bv = 0; ad = 0; bd = 0;
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; idle[i] = 0; m_xo[i] = '0; m_xv[i] = 0; m_fe[i] = 0;
      xv_cnt[i] = 0; fe_cnt[i] = 0;
    end
    #2;
    cyc(1'b1, 0, 16'h0, 0, 16'h0);
    cyc(1'b1, 0, 16'h0, 0, 16'h0);
    chk("reset_x_out", a_xo, 64'h0);
    chk("reset_words_held", 64'(a_wh), 64'd0);
    ia(1);

    // Single frame, words_held 1,2,3,0
    wa(16'h0001); chk("wh_seq1", 64'(a_wh), 64'd1);
    wa(16'h0002); chk("wh_seq2", 64'(a_wh), 64'd2);
    wa(16'h0003); chk("wh_seq3", 64'(a_wh), 64'd3);
    chk("no_xv_early", 64'(a_xv), 64'd0);
    wa(16'h0004); chk("wh_seq0", 64'(a_wh), 64'd0);
    chk("frame1_xv", 64'(a_xv), 64'd1);
    chk("frame1_xo", a_xo, 64'h0004_0003_0002_0001);
    ia(1);
    chk("frame1_xv_drop", 64'(a_xv), 64'd0);

    // Back-to-back frames
    base = xv_cnt[0];
    for (int k = 1; k <= 4; k++) wa(16'h0010 + 16'(k));
    chk("b2b_xo1", a_xo, 64'h0014_0013_0012_0011);
    for (int k = 1; k <= 4; k++) begin
      wa(16'h0020 + 16'(k));
      if (k == 1) chk("b2b_xo1_hold", a_xo, 64'h0014_0013_0012_0011);
    end
    chk("b2b_xo2", a_xo, 64'h0024_0023_0022_0021);
    ia(1);
    chk("b2b_pulses", 64'(xv_cnt[0] - base), 64'd2);

    // Watchdog discard
    base = fe_cnt[0];
    wa(16'hAAAA); wa(16'hBBBB);
    ia(4);
    chk("wd_not_yet", 64'(a_fe), 64'd0);
    ia(1);
    chk("wd_fe", 64'(a_fe), 64'd1);
    chk("wd_busy", 64'(a_busy), 64'd0);
    chk("wd_wh", 64'(a_wh), 64'd0);
    chk("wd_xo_kept", a_xo, 64'h0024_0023_0022_0021);
    ia(3);
    chk("wd_one_pulse", 64'(fe_cnt[0] - base), 64'd1);
    for (int k = 1; k <= 4; k++) wa(16'(k));
    chk("wd_after_xo", a_xo, 64'h0004_0003_0002_0001);

    // Gaps one short of the timeout
    base = fe_cnt[0];
    wa(16'h00A0); ia(4);
    wa(16'h00B0); ia(4);
    wa(16'h00C0); ia(4);
    wa(16'h00D0);
    chk("gap4_xv", 64'(a_xv), 64'd1);
    chk("gap4_xo", a_xo, 64'h00D0_00C0_00B0_00A0);
    chk("gap4_no_fe", 64'(fe_cnt[0] - base), 64'd0);
    ia(2);

    // Reset mid-frame
    base = fe_cnt[0];
    wa(16'h0099); wa(16'h0098);
    cyc(1'b1, 0, 16'h0, 0, 16'h0);
    chk("rst_mid_wh", 64'(a_wh), 64'd0);
    chk("rst_mid_xo", a_xo, 64'h0);
    ia(1);
    for (int k = 5; k <= 8; k++) wa(16'(k));
    chk("rst_mid_frame", a_xo, 64'h0008_0007_0006_0005);
    ia(8);
    chk("rst_mid_no_fe", 64'(fe_cnt[0] - base), 64'd0);

    // Watchdog disabled build
    base = xv_cnt[1];
    cyc(1'b0, 0, 16'h0, 1'b1, 16'h0C01);
    cyc(1'b0, 0, 16'h0, 1'b1, 16'h0C02);
    ia(200);
    chk("nowd_busy", 64'(b_busy), 64'd1);
    chk("nowd_wh", 64'(b_wh), 64'd2);
    cyc(1'b0, 0, 16'h0, 1'b1, 16'h0C03);
    cyc(1'b0, 0, 16'h0, 1'b1, 16'h0C04);
    chk("nowd_xv", 64'(b_xv), 64'd1);
    chk("nowd_xo", b_xo, 64'h0C04_0C03_0C02_0C01);
    ia(2);
    chk("nowd_one_frame", 64'(xv_cnt[1] - base), 64'd1);
    chk("nowd_no_fe", 64'(fe_cnt[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_flow_collector.md
Name: data_flow_collector

Overview:
- Deserializer for the inter-layer word stream: accepts one `dataWidth word per valid cycle and packs NUM_NEURON_LAYER consecutive words into one layer-wide vector.
- Presents the vector with a single-cycle valid pulse, for use as the input vector of the next layer's neurons.
- Sits at the receiving end of the serial word link that carries a layer's outputs between blocks. Word order is LSB-first: the first word received occupies bits [`dataWidth-1:0].
- Includes a gap watchdog that discards stalled partial frames.

Parameters:
- NUM_NEURON_LAYER, 30, words per frame; also the number of `dataWidth slices in x_out.
- GAP_TIMEOUT, 64, idle cycles allowed inside a partial frame before it is discarded. A value of 0 disables the watchdog.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in_valid  input  1  in_data carries a word this cycle. No backpressure: every valid word is accepted.
- in_data  input  `dataWidth  serial data word.
- x_valid  output  1  one-cycle pulse: x_out holds a newly completed frame.
- x_out  output  NUM_NEURON_LAYER*`dataWidth  last completed frame; word k at bits [(k+1)*`dataWidth-1 : k*`dataWidth].
- words_held  output  $clog2(NUM_NEURON_LAYER+1)  words collected in the current partial frame.
- busy  output  1  high while a partial frame is in progress (state COLLECT).
- frame_error  output  1  one-cycle pulse: a partial frame was discarded by the watchdog.

Behaviour:
- Reset (synchronous, any state, mid-frame included):
  - state=IDLE; x_valid=0, x_out=0, words_held=0, busy=0, frame_error=0.
  - Internal shift buffer and gap counter cleared. A partial frame is lost silently, with no frame_error.
- States: IDLE (no words held) and COLLECT (1..NUM_NEURON_LAYER-1 words held).
- Packing: the internal buffer shifts right by `dataWidth per accepted word, with in_data inserted at the top slice. After NUM_NEURON_LAYER words, word 0 therefore sits in the lowest slice.
- IDLE:
  - On data_in_valid, capture the word, set words_held=1, go to COLLECT.
  - If NUM_NEURON_LAYER==1, the frame completes immediately instead.
- COLLECT:
  - Each valid cycle captures a word and increments words_held.
  - When the accepted word is word NUM_NEURON_LAYER-1:
    - x_out is loaded with the full packed vector on that same clock edge.
    - x_valid=1 in the following cycle only.
    - words_held returns to 0; state goes to IDLE.
- Latency: x_valid and the new x_out appear 1 cycle after the final word's valid cycle.
- Back-to-back frames: a valid word in the cycle immediately after completion (while x_valid=1) is word 0 of the next frame. No gap cycle is required.
- x_out holding: x_out stays stable between completions and is never altered by partial frames or by watchdog discards.
- Watchdog (GAP_TIMEOUT>0):
  - The gap counter clears on every accepted word and increments on each COLLECT cycle with data_in_valid=0.
  - When the counter reaches GAP_TIMEOUT: discard the partial frame, set words_held=0, go to IDLE, and pulse frame_error=1 for exactly the next cycle.
  - If data_in_valid is high in the cycle the counter would reach GAP_TIMEOUT, the word wins: it is accepted and the counter clears.
  - The watchdog is inactive in IDLE.
- busy equals (state==COLLECT). words_held is a registered count, never exceeds NUM_NEURON_LAYER-1, and reads 0 in the x_valid cycle.
- x_valid and frame_error are never high in the same cycle.

Test Plan (bench uses NUM_NEURON_LAYER=4, `dataWidth=16, GAP_TIMEOUT=5):
- Reset then words 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles -> x_valid high for exactly 1 cycle, one cycle after the 4th word; x_out=0x0004_0003_0002_0001; words_held sequence 1,2,3,0.
- Two frames streamed with no gap (0x11..0x14 then 0x21..0x24) -> two single-cycle x_valid pulses 4 cycles apart; x_out=0x0014_0013_0012_0011 then 0x0024_0023_0022_0021.
- Words 0xAAAA,0xBBBB then 5 idle cycles -> frame_error pulses once; busy drops; words_held=0; x_out unchanged. A following 4-word frame 1,2,3,4 -> x_out=0x0004_0003_0002_0001.
- Words with 4 idle cycles between each (gap one short of timeout) -> no frame_error; frame completes normally with the correct ordering.
- Assert reset after 2 words, release, send 4 words 5,6,7,8 -> no frame_error at any point; x_out=0x0008_0007_0006_0005.
- GAP_TIMEOUT=0 build: 2 words, 200 idle cycles, 2 more words -> no frame_error; a single frame completes containing all 4 words in order.
